// File: rtl/parametrik_bolme_birimi_pkg.sv
// Shared definitions for the iterative divider: operation codes, FSM states
// and the iteration-counter width helper.
package bolme_paket;

   typedef enum logic [1:0] {
      BOLME_DIVU = 2'b00,
      BOLME_REMU = 2'b01,
      BOLME_DIV  = 2'b10,
      BOLME_REM  = 2'b11
   } islem_t;

   typedef enum logic [1:0] {
      BOS     = 2'b00,
      HAZIRLA = 2'b01,
      BOL     = 2'b10,
      SONUC   = 2'b11
   } durum_t;

   function automatic int sayac_genisligi(input int veri_w, input int adim);
      return $clog2(veri_w / adim + 1);
   endfunction

endpackage

// File: rtl/parametrik_bolme_birimi_adimi.sv
// One combinational restoring-division step on a VERI_W+1 bit partial
// remainder; the top chains ADIM of these per cycle.
module bolme_adimi #(
   parameter int VERI_W = 32
) (
   input  logic [VERI_W:0]   kalan_i,
   input  logic [VERI_W-1:0] bolen_i,
   input  logic              bit_i,
   output logic [VERI_W:0]   kalan_o,
   output logic              bolum_biti_o
);

   logic [VERI_W:0] w_kaydirilmis;
   logic [VERI_W:0] w_fark;
   logic            w_odunc;

   assign w_kaydirilmis = {kalan_i[VERI_W-1:0], bit_i};
   assign w_fark        = w_kaydirilmis - {1'b0, bolen_i};

   // A set top bit on the incoming remainder means the shifted value exceeds
   // any divisor, so the subtraction can never truly borrow in that case.
   assign w_odunc       = w_fark[VERI_W] & ~kalan_i[VERI_W];
   assign bolum_biti_o  = ~w_odunc;
   assign kalan_o       = w_odunc ? w_kaydirilmis : w_fark;

endmodule

// File: rtl/parametrik_bolme_birimi.sv
// Iterative signed/unsigned divider with RISC-V DIV/DIVU/REM/REMU semantics.
// Optional result cache enabled by defining BOLME_ONBELLEK_EN.
module parametrik_bolme_birimi
   import bolme_paket::*;
#(
   parameter int VERI_W = 32,
   parameter int ADIM   = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              istek_gecerli_i,
   output logic              istek_hazir_o,
   input  logic [1:0]        islem_i,
   input  logic [VERI_W-1:0] bolunen_i,
   input  logic [VERI_W-1:0] bolen_i,
   input  logic              iptal_i,
   output logic              sonuc_gecerli_o,
   input  logic              sonuc_hazir_i,
   output logic [VERI_W-1:0] sonuc_o
);

   localparam int              ADIM_SAYISI = VERI_W / ADIM;
   localparam int              SW          = sayac_genisligi(VERI_W, ADIM);
   localparam logic [SW-1:0]   SAYAC_BAS   = SW'(ADIM_SAYISI);
   localparam logic [SW-1:0]   SAYAC_SON   = SW'(1);
   localparam logic [VERI_W-1:0] EN_NEGATIF = {1'b1, {(VERI_W-1){1'b0}}};

   durum_t              r_durum;
   islem_t              r_islem;
   logic [VERI_W-1:0]   r_bolunen;
   logic [VERI_W-1:0]   r_bolen;
   logic [VERI_W:0]     r_kalan;
   logic [SW-1:0]       r_sayac;
   logic                r_bolum_isareti;
   logic                r_kalan_isareti;
   logic                r_sonuc_gecerli;
   logic [VERI_W-1:0]   r_sonuc;

`ifdef BOLME_ONBELLEK_EN
   logic                r_ob_gecerli;
   logic                r_ob_isaretli;
   logic                r_ob_sa;
   logic                r_ob_sb;
   logic [VERI_W-1:0]   r_ob_a;
   logic [VERI_W-1:0]   r_ob_b;
   logic [VERI_W-1:0]   r_ob_bolum;
   logic [VERI_W-1:0]   r_ob_kalan;
   logic                r_ozel;
   logic                w_onbellek_isabet;
`endif

   logic                w_isaretli;
   logic                w_a_neg;
   logic                w_b_neg;
   logic [VERI_W-1:0]   w_a_mag;
   logic [VERI_W-1:0]   w_b_mag;
   logic                w_sifir;
   logic                w_tasma;
   logic [VERI_W-1:0]   w_kalan_alt;
   logic [VERI_W-1:0]   w_bolum_son;
   logic [VERI_W-1:0]   w_kalan_son;
   logic [VERI_W:0]     w_zincir [0:ADIM];
   logic [ADIM-1:0]     w_bolum_bitleri;

   assign istek_hazir_o   = (r_durum == BOS);
   assign sonuc_gecerli_o = r_sonuc_gecerli;
   assign sonuc_o         = r_sonuc;

   // Operand magnitudes and special-case detection, used while in HAZIRLA
   assign w_isaretli  = r_islem[1];
   assign w_a_neg     = w_isaretli & r_bolunen[VERI_W-1];
   assign w_b_neg     = w_isaretli & r_bolen[VERI_W-1];
   assign w_a_mag     = w_a_neg ? -r_bolunen : r_bolunen;
   assign w_b_mag     = w_b_neg ? -r_bolen : r_bolen;
   assign w_sifir     = (r_bolen == '0);
   assign w_tasma     = w_isaretli && (r_bolunen == EN_NEGATIF) && (r_bolen == '1);

   assign w_kalan_alt = r_kalan[VERI_W-1:0];
   assign w_bolum_son = r_bolum_isareti ? -r_bolunen : r_bolunen;
   assign w_kalan_son = r_kalan_isareti ? -w_kalan_alt : w_kalan_alt;

`ifdef BOLME_ONBELLEK_EN
   assign w_onbellek_isabet = r_ob_gecerli && (r_ob_isaretli == w_isaretli) &&
                              (r_ob_a == w_a_mag) && (r_ob_b == w_b_mag) &&
                              (r_ob_sa == w_a_neg) && (r_ob_sb == w_b_neg);
`endif

   // r_bolunen feeds dividend bits from the top and collects quotient bits at the bottom
   assign w_zincir[0] = r_kalan;
   for (genvar k = 0; k < ADIM; k++) begin : g_adim
      bolme_adimi #(.VERI_W(VERI_W)) u_adim (
         .kalan_i      (w_zincir[k]),
         .bolen_i      (r_bolen),
         .bit_i        (r_bolunen[VERI_W-1-k]),
         .kalan_o      (w_zincir[k+1]),
         .bolum_biti_o (w_bolum_bitleri[ADIM-1-k])
      );
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_durum         <= BOS;
         r_islem         <= BOLME_DIVU;
         r_bolunen       <= '0;
         r_bolen         <= '0;
         r_kalan         <= '0;
         r_sayac         <= '0;
         r_bolum_isareti <= 1'b0;
         r_kalan_isareti <= 1'b0;
         r_sonuc_gecerli <= 1'b0;
         r_sonuc         <= '0;
`ifdef BOLME_ONBELLEK_EN
         r_ob_gecerli    <= 1'b0;
         r_ob_isaretli   <= 1'b0;
         r_ob_sa         <= 1'b0;
         r_ob_sb         <= 1'b0;
         r_ob_a          <= '0;
         r_ob_b          <= '0;
         r_ob_bolum      <= '0;
         r_ob_kalan      <= '0;
         r_ozel          <= 1'b0;
`endif
      end else if (iptal_i) begin
         r_durum         <= BOS;
         r_sonuc_gecerli <= 1'b0;
`ifdef BOLME_ONBELLEK_EN
         r_ob_gecerli    <= 1'b0;
`endif
      end else begin
         case (r_durum)
            BOS: begin
               if (istek_gecerli_i) begin
                  r_islem   <= islem_t'(islem_i);
                  r_bolunen <= bolunen_i;
                  r_bolen   <= bolen_i;
                  r_durum   <= HAZIRLA;
               end
            end
            HAZIRLA: begin
               r_kalan         <= '0;
               r_sayac         <= SAYAC_BAS;
               r_bolum_isareti <= w_a_neg ^ w_b_neg;
               r_kalan_isareti <= w_a_neg;
               r_bolunen       <= w_a_mag;
               r_bolen         <= w_b_mag;
               // Special cases preload quotient/remainder so SONUC needs no extra path
               if (w_sifir) begin
                  r_bolunen       <= '1;
                  r_kalan         <= {1'b0, r_bolunen};
                  r_bolum_isareti <= 1'b0;
                  r_kalan_isareti <= 1'b0;
                  r_durum         <= SONUC;
`ifdef BOLME_ONBELLEK_EN
                  r_ozel          <= 1'b1;
`endif
               end else if (w_tasma) begin
                  r_bolunen       <= EN_NEGATIF;
                  r_kalan         <= '0;
                  r_bolum_isareti <= 1'b0;
                  r_kalan_isareti <= 1'b0;
                  r_durum         <= SONUC;
`ifdef BOLME_ONBELLEK_EN
                  r_ozel          <= 1'b1;
               end else if (w_onbellek_isabet) begin
                  r_bolunen       <= r_ob_bolum;
                  r_kalan         <= {1'b0, r_ob_kalan};
                  r_ozel          <= 1'b1;
                  r_durum         <= SONUC;
`endif
               end else begin
                  r_durum         <= BOL;
`ifdef BOLME_ONBELLEK_EN
                  r_ozel          <= 1'b0;
                  r_ob_gecerli    <= 1'b0;
                  r_ob_isaretli   <= w_isaretli;
                  r_ob_sa         <= w_a_neg;
                  r_ob_sb         <= w_b_neg;
                  r_ob_a          <= w_a_mag;
                  r_ob_b          <= w_b_mag;
`endif
               end
            end
            BOL: begin
               r_kalan   <= w_zincir[ADIM];
               r_bolunen <= {r_bolunen[VERI_W-ADIM-1:0], w_bolum_bitleri};
               r_sayac   <= r_sayac - SAYAC_SON;
               if (r_sayac == SAYAC_SON) begin
                  r_durum <= SONUC;
               end
            end
            SONUC: begin
               if (!r_sonuc_gecerli) begin
                  r_sonuc         <= r_islem[0] ? w_kalan_son : w_bolum_son;
                  r_sonuc_gecerli <= 1'b1;
`ifdef BOLME_ONBELLEK_EN
                  if (!r_ozel) begin
                     r_ob_bolum   <= r_bolunen;
                     r_ob_kalan   <= w_kalan_alt;
                     r_ob_gecerli <= 1'b1;
                  end
`endif
               end else if (sonuc_hazir_i) begin
                  r_sonuc_gecerli <= 1'b0;
                  r_durum         <= BOS;
               end
            end
            default: r_durum <= BOS;
         endcase
      end
   end

endmodule

// File: tb/tb_parametrik_bolme_birimi.sv
// Scoreboard bench for parametrik_bolme_birimi: stimulus pushes expected
// results and latencies, a negedge monitor pops and compares them.
module tb_parametrik_bolme_birimi;

   localparam int W = 32;
`ifdef BOLME_ONBELLEK_EN
   localparam int HIT_LAT = 2;
`else
   localparam int HIT_LAT = 18;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          istekGecerli = 1'b0;
   logic          iptal = 1'b0;
   logic          sonucHazir = 1'b1;
   logic [1:0]    islem = 2'b00;
   logic [W-1:0]  bolunen = '0;
   logic [W-1:0]  bolen = '0;
   logic          istekHazir;
   logic          sonucGecerli;
   logic [W-1:0]  sonuc;

   logic          xGecerli = 1'b0;
   logic          xIptal = 1'b0;
   logic          xHazir = 1'b1;
   logic [1:0]    xIslem = 2'b00;
   logic [W-1:0]  xA = '0;
   logic [W-1:0]  xB = '0;
   logic          x1IstekHazir, x1Gecerli, x4IstekHazir, x4Gecerli;
   logic [W-1:0]  x1Sonuc, x4Sonuc;

   typedef struct {
      logic [W-1:0] deger;
      int           gecikme;
      string        ad;
   } beklenen_t;

   beklenen_t kuyruk[$];
   int compared = 0;
   int mismatched = 0;
   int cycle = 0;
   int kabulCycle = 0;
   logic oncekiGecerli = 1'b0;

   always #5 clk = ~clk;

   parametrik_bolme_birimi #(.VERI_W(W), .ADIM(2)) dut (
      .clk_i(clk), .rst_i(rst), .istek_gecerli_i(istekGecerli), .istek_hazir_o(istekHazir),
      .islem_i(islem), .bolunen_i(bolunen), .bolen_i(bolen), .iptal_i(iptal),
      .sonuc_gecerli_o(sonucGecerli), .sonuc_hazir_i(sonucHazir), .sonuc_o(sonuc)
   );

   parametrik_bolme_birimi #(.VERI_W(W), .ADIM(1)) dutAdim1 (
      .clk_i(clk), .rst_i(rst), .istek_gecerli_i(xGecerli), .istek_hazir_o(x1IstekHazir),
      .islem_i(xIslem), .bolunen_i(xA), .bolen_i(xB), .iptal_i(xIptal),
      .sonuc_gecerli_o(x1Gecerli), .sonuc_hazir_i(xHazir), .sonuc_o(x1Sonuc)
   );

   parametrik_bolme_birimi #(.VERI_W(W), .ADIM(4)) dutAdim4 (
      .clk_i(clk), .rst_i(rst), .istek_gecerli_i(xGecerli), .istek_hazir_o(x4IstekHazir),
      .islem_i(xIslem), .bolunen_i(xA), .bolen_i(xB), .iptal_i(xIptal),
      .sonuc_gecerli_o(x4Gecerli), .sonuc_hazir_i(xHazir), .sonuc_o(x4Sonuc)
   );

   // Free-running edge counter used to time results against their acceptance edge
   always @(posedge clk) cycle++;

   task automatic checkOutput(input string ad, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", ad, actual, expected);
      end
   endtask

   // Monitor: records acceptances and checks each presented result against the queue head
   always @(negedge clk) begin
      if (rst) begin
         oncekiGecerli = 1'b0;
      end else begin
         if (istekGecerli && istekHazir && !iptal) kabulCycle = cycle + 1;
         if (sonucGecerli) begin
            if (kuyruk.size() == 0) begin
               checkOutput("unexpectedValid", sonucGecerli, 0);
            end else begin
               if (!oncekiGecerli)
                  checkOutput({kuyruk[0].ad, "_latency"}, cycle - kabulCycle, kuyruk[0].gecikme);
               checkOutput(kuyruk[0].ad, sonuc, kuyruk[0].deger);
               checkOutput({kuyruk[0].ad, "_reqReadyLow"}, istekHazir, 0);
               if (sonucHazir) void'(kuyruk.pop_front());
            end
         end
         oncekiGecerli = sonucGecerli && !sonucHazir;
      end
   end

   task automatic waitDrain(input string ad);
      int t = 0;
      while (kuyruk.size() != 0 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (kuyruk.size() != 0) begin
         checkOutput({ad, "_resultTimeout"}, kuyruk.size(), 0);
         kuyruk.delete();
      end
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] deger, input int gecikme, input string ad,
                                input bit push, input bit bekle);
      int t = 0;
      while (!istekHazir && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!istekHazir) checkOutput({ad, "_reqTimeout"}, istekHazir, 1);
      if (push) kuyruk.push_back('{deger, gecikme, ad});
      islem = op;
      bolunen = a;
      bolen = b;
      istekGecerli = 1'b1;
      @(posedge clk); #1;
      istekGecerli = 1'b0;
      if (bekle) waitDrain(ad);
   endtask

   task automatic watchNoResult(input string ad);
      logic goruldu = 1'b0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         if (sonucGecerli) goruldu = 1'b1;
      end
      checkOutput({ad, "_noResult"}, goruldu, 0);
   endtask

   task automatic checkRadix();
      int lat1 = -1;
      int lat4 = -1;
      logic [W-1:0] v1 = '0;
      logic [W-1:0] v4 = '0;
      xIslem = 2'b00;
      xA = 32'd100;
      xB = 32'd7;
      xGecerli = 1'b1;
      @(posedge clk); #1;
      xGecerli = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (x1Gecerli && lat1 < 0) begin lat1 = k; v1 = x1Sonuc; end
         if (x4Gecerli && lat4 < 0) begin lat4 = k; v4 = x4Sonuc; end
      end
      checkOutput("adim1_latency", lat1, 34);
      checkOutput("adim1_divu_100_7", v1, 14);
      checkOutput("adim4_latency", lat4, 10);
      checkOutput("adim4_divu_100_7", v4, 14);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset_reqReady", istekHazir, 1);
      checkOutput("reset_valid", sonucGecerli, 0);
      checkOutput("reset_result", sonuc, 0);
      @(posedge clk); #1;

      applyStimulus(2'b00, 32'd100, 32'd7, 32'd14, 18, "divu_100_7", 1, 1);
      applyStimulus(2'b01, 32'd100, 32'd7, 32'd2, HIT_LAT, "remu_100_7", 1, 1);
      applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 18, "div_m7_2", 1, 1);
      applyStimulus(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, HIT_LAT, "rem_m7_2", 1, 1);
      applyStimulus(2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 18, "rem_7_m2", 1, 1);
      applyStimulus(2'b00, 32'd5, 32'd0, 32'hFFFFFFFF, 2, "divu_5_0", 1, 1);
      applyStimulus(2'b11, 32'h80000000, 32'd0, 32'h80000000, 2, "rem_min_0", 1, 1);
      applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, "div_overflow", 1, 1);
      applyStimulus(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2, "rem_overflow", 1, 1);

      // Backpressure: result must be held while the consumer stalls
      sonucHazir = 1'b0;
      applyStimulus(2'b00, 32'd1000, 32'd10, 32'd100, 18, "bp_divu_1000_10", 1, 0);
      begin
         int t = 0;
         while (!sonucGecerli && t < 40) begin
            @(posedge clk); #1;
            t++;
         end
         checkOutput("bp_validRose", sonucGecerli, 1);
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checkOutput("bp_reqReady", istekHazir, 0);
         checkOutput("bp_validHeld", sonucGecerli, 1);
      end
      sonucHazir = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_releaseReady", istekHazir, 1);
      applyStimulus(2'b00, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 18, "after_bp", 1, 1);

      // Flush in the middle of BOL
      applyStimulus(2'b00, 32'd100, 32'd7, 32'd0, 0, "flush_req", 0, 0);
      repeat (6) begin @(posedge clk); #1; end
      iptal = 1'b1;
      @(posedge clk); #1;
      iptal = 1'b0;
      checkOutput("flush_reqReady", istekHazir, 1);
      checkOutput("flush_valid", sonucGecerli, 0);
      watchNoResult("flush");
      applyStimulus(2'b00, 32'd9, 32'd3, 32'd3, 18, "divu_9_3_afterFlush", 1, 1);

      // Asynchronous reset in the middle of BOL
      applyStimulus(2'b00, 32'd100, 32'd7, 32'd0, 0, "rst_req", 0, 0);
      repeat (6) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      checkOutput("midRst_reqReady", istekHazir, 1);
      checkOutput("midRst_valid", sonucGecerli, 0);
      checkOutput("midRst_result", sonuc, 0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      watchNoResult("midRst");
      applyStimulus(2'b00, 32'd9, 32'd3, 32'd3, 18, "divu_9_3_afterRst", 1, 1);

      // Signed pair on identical operands: the remainder may come from the cache
      applyStimulus(2'b10, 32'd1000, 32'hFFFFFFFD, 32'hFFFFFEB3, 18, "div_1000_m3", 1, 1);
      applyStimulus(2'b11, 32'd1000, 32'hFFFFFFFD, 32'd1, HIT_LAT, "rem_1000_m3", 1, 1);

      checkRadix();

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/parametrik_bolme_birimi.md
Name: parametrik_bolme_birimi

Overview:
Parametrised iterative integer divider for the execute stage. It supports signed and unsigned division and remainder (RISC-V DIV/DIVU/REM/REMU semantics), with configurable width and radix (quotient bits resolved per cycle). Operands are latched on a valid/ready request handshake. The result is held on a valid/ready response handshake, so the block tolerates pipeline stalls and flushes.

Parameters:
VERI_W, 32, operand and result width in bits; must be at least 8 and even.
ADIM, 2, quotient bits resolved per cycle; legal values 1, 2, 4; must divide VERI_W.

Ports:
clk_i  input  1  clock, all state updates on the rising edge
rst_i  input  1  reset, asynchronous and active-high
istek_gecerli_i  input  1  request valid
istek_hazir_o  output  1  block can accept a request
islem_i  input  2  operation: 00 DIVU, 01 REMU, 10 DIV, 11 REM
bolunen_i  input  VERI_W  dividend
bolen_i  input  VERI_W  divisor
iptal_i  input  1  flush: abandon the current operation
sonuc_gecerli_o  output  1  result valid
sonuc_hazir_i  input  1  consumer accepts the result
sonuc_o  output  VERI_W  quotient or remainder

Behaviour:
- Reset values:
  - istek_hazir_o=1, sonuc_gecerli_o=0, sonuc_o=0.
  - State BOS.
  - All internal registers are 0.
- FSM states: BOS, HAZIRLA, BOL, SONUC.
  - BOS: istek_hazir_o=1. On istek_gecerli_i&istek_hazir_o, latch islem_i, bolunen_i and bolen_i, then go to HAZIRLA. Inputs are not sampled again after this.
  - HAZIRLA:
    - For signed ops, take the magnitude of any negative operand. Store the sign of the quotient (sign(a)^sign(b)) and the sign of the remainder (sign(a)).
    - Load a VERI_W+1 bit partial-remainder register with 0 and an iteration counter with VERI_W/ADIM.
    - If a special case applies (see below), go directly to SONUC. Otherwise go to BOL.
  - BOL: perform ADIM chained restoring steps per cycle and decrement the counter. When the counter reaches 1, the next state is SONUC. BOL occupies exactly VERI_W/ADIM cycles.
  - SONUC:
    - sonuc_o is registered: conditionally negated quotient or remainder selected by the latched islem.
    - sonuc_gecerli_o=1. sonuc_o and sonuc_gecerli_o are held stable until sonuc_hazir_i=1, then the FSM returns to BOS.
    - istek_hazir_o=0 while in SONUC; there is no back-to-back overlap.
- Latency: take the acceptance edge as cycle 0. sonuc_gecerli_o rises after cycle VERI_W/ADIM+2 (18 for the defaults). Special cases take 2 cycles.
- Special cases, decided in HAZIRLA:
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return the dividend unchanged.
  - Signed overflow (dividend = most negative value, divisor = all ones): DIV returns the most negative value; REM returns 0.
- Width rules:
  - Subtraction is done at VERI_W+1 bits. Bit VERI_W is the borrow: 1 means restore and the quotient bit is 0.
  - Negation is two's complement at VERI_W bits.
- iptal_i: synchronous, highest priority after reset. In any state, the next state is BOS, sonuc_gecerli_o=0 and any pending result is discarded. iptal_i together with a request in BOS means the request is not accepted.
- Reset mid-operation: immediate return to the reset values; no result is produced.
- istek_hazir_o is combinational from state only. It never depends on istek_gecerli_i.

Optional Feature:
BOLME_ONBELLEK_EN:
- Defined: registers the last completed unsigned-magnitude operands, signs, quotient and remainder, plus a valid bit. A request whose latched operands and signedness match the stored ones skips BOL and goes HAZIRLA to SONUC, so a DIV-then-REM pair costs 2 cycles for the second op.
- Invalidation: the valid bit clears on reset, on iptal_i, and when a divide is abandoned.
- Not defined: no cache registers; every non-special request iterates.

Decomposition:
- Shared package bolme_paket:
  - operation codes BOLME_DIVU/REMU/DIV/REM;
  - state encoding BOS/HAZIRLA/BOL/SONUC;
  - function for the iteration-count width, $clog2(VERI_W/ADIM+1).
- Sub-module bolme_adimi: combinational single restoring step (partial remainder in/out, dividend bit in, quotient bit out, width VERI_W+1). It is instantiated ADIM times in a generate chain.

Test Plan:
- DIVU 100/7 -> 14; REMU 100/7 -> 2. sonuc_gecerli_o rises exactly at cycle 18 (defaults), checked also for ADIM=1 (34) and ADIM=4 (10).
- DIV -7/2 (0xFFFFFFF9/2) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; REM 7/-2 -> 1.
- DIVU 5/0 -> 0xFFFFFFFF; REM 0x80000000/0 -> 0x80000000; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. All within 2 cycles.
- Backpressure: hold sonuc_hazir_i=0 for 5 cycles -> sonuc_o stable, istek_hazir_o=0. Release -> BOS the next cycle and a new request is accepted.
- iptal_i at cycle 6 of BOL -> sonuc_gecerli_o never rises, istek_hazir_o=1 the next cycle. Then DIVU 9/3 -> 3 with normal latency. Repeat with async rst_i mid-BOL.
- With BOLME_ONBELLEK_EN: DIV 1000/-3 -> 0xFFFFFFFF_FEB3 sign-extended (-333, 0xFFFFFEB3), then REM 1000/-3 -> 1 in 2 cycles. Without the macro, the REM takes 18 cycles.
